// File: rtl/bit_scan_unit_if.sv
// Request/response bundle for bit_scan_unit: operand in with valid/ready, count out with
// valid/ready, plus a busy flag.
interface bit_scan_unit_if #(
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_count;
    logic             out_zero;
    logic             busy;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_count, out_zero, busy
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_count, out_zero, busy
    );
endinterface

// File: rtl/bit_scan_unit.sv
// Multi-cycle CLZ / CTZ / CPOP engine scanning CHUNK bits per cycle from the MSB of the
// latched operand; CLZ and CTZ stop at the first non-zero chunk.
module bit_scan_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    bit_scan_unit_if.slave   scan_io
);
    localparam int unsigned CNT_W  = $clog2(WIDTH) + 1;
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LastIdx  = IDX_W'(NCHUNK - 1);
    localparam logic [1:0]       ModeClz  = 2'b00;
    localparam logic [1:0]       ModeCtz  = 2'b01;
    localparam logic [1:0]       ModeCpop = 2'b10;

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             zero_q, zero_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic             in_ready;
    logic [WIDTH-1:0] data_rev;
    logic [WIDTH-1:0] shifted;
    logic [CHUNK-1:0] chunk;
    logic [CNT_W-1:0] chunk_lz;
    logic [CNT_W-1:0] chunk_pop;
    logic             found;

    assign in_ready = (state_q == StIdle) && !rst;

    // CTZ is a CLZ of the bit-reversed operand, so both share the MSB-first scan.
    always_comb begin
        for (int i = 0; i < int'(WIDTH); i++) begin
            data_rev[i] = scan_io.in_data[WIDTH-1-i];
        end
    end

    always_comb begin
        shifted   = data_q << (32'(idx_q) * CHUNK);
        chunk     = shifted[WIDTH-1 -: CHUNK];
        chunk_lz  = '0;
        chunk_pop = '0;
        found     = 1'b0;
        for (int i = int'(CHUNK) - 1; i >= 0; i--) begin
            chunk_pop = chunk_pop + CNT_W'(chunk[i]);
            if (chunk[i]) begin
                found = 1'b1;
            end else if (!found) begin
                chunk_lz = chunk_lz + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        mode_d  = mode_q;
        count_d = count_q;
        zero_d  = zero_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (scan_io.in_valid && in_ready) begin
                    data_d  = (scan_io.in_mode == ModeCtz) ? data_rev : scan_io.in_data;
                    mode_d  = scan_io.in_mode;
                    zero_d  = (scan_io.in_data == '0);
                    count_d = '0;
                    idx_d   = '0;
                    state_d = (scan_io.in_mode == 2'b11) ? StDone : StScan;
                end
            end
            StScan: begin
                if (mode_q == ModeCpop || chunk == '0) begin
                    count_d = count_q + ((mode_q == ModeCpop) ? chunk_pop : CNT_W'(CHUNK));
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    count_d = count_q + chunk_lz;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (scan_io.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            data_q  <= '0;
            mode_q  <= ModeClz;
            count_q <= '0;
            zero_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            count_q <= count_d;
            zero_q  <= zero_d;
            idx_q   <= idx_d;
        end
    end

    assign scan_io.in_ready  = in_ready;
    assign scan_io.out_valid = (state_q == StDone);
    assign scan_io.out_count = count_q;
    assign scan_io.out_zero  = zero_q;
    assign scan_io.busy      = (state_q != StIdle);
endmodule
